mc_ctrl_fsm: RTL
================

Name: mc_ctrl_fsm

Overview:
Multicycle MIPS control FSM that sequences the shared datapath: one ALU, one unified memory port, and the register file. The datapath steering is built from the existing 2:1 and 4:1 select muxes. This block drives every mux select and every write strobe each cycle, based on the latched opcode, the ALU zero flag and a memory-ready handshake. It replaces the single-cycle decoder when the core is built in multicycle mode.

Parameters:
MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready; 0 = mem_ready ignored (treated as 1)
STATE_W, 4, width of state encoding and of dbg_state

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
opcode  input  6  instruction[31:26] from IR; valid from DECODE onward
zero  input  1  ALU zero flag, combinational, valid in BRANCH
mem_ready  input  1  memory completes read/write this cycle
pc_we  output  1  PC write strobe
ir_we  output  1  instruction register write strobe
mem_we  output  1  memory write strobe
reg_we  output  1  register file write strobe
iord  output  1  2:1 mux select for memory address; 0 = PC, 1 = ALUOut
reg_dst  output  1  2:1 mux select for write register; 0 = rt, 1 = rd
mem_to_reg  output  1  2:1 mux select for write data; 0 = ALUOut, 1 = MDR
alu_src_a  output  1  2:1 mux select for ALU A; 0 = PC, 1 = regA
alu_src_b  output  2  4:1 mux select for ALU B; 00 = regB, 01 = const 4, 10 = sign-extended imm, 11 = sign-extended imm<<2
pc_src  output  2  4:1 mux select for next PC; 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 unused
alu_op  output  2  00 = add, 01 = sub, 10 = decode by funct
illegal  output  1  one-cycle pulse on unknown opcode
dbg_state  output  STATE_W  current state

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst.
- While rst=1: state=FETCH. All strobes (pc_we, ir_we, mem_we, reg_we, illegal) = 0. Selects hold their FETCH values: iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, alu_op=00, reg_dst=0, mem_to_reg=0.
- Outputs are combinational from the state. pc_we, ir_we and mem_we are additionally qualified by mem_ready or zero, as listed below.
- Selects not listed for a state = 0. Strobes not listed for a state = 0.
- States and outputs, with next state:
- FETCH (0): iord=0, alu_src_a=0, alu_src_b=01, pc_src=00, alu_op=00, ir_we=pc_we=mem_ready. Next: mem_ready ? DECODE : FETCH.
- DECODE (1): alu_src_a=0, alu_src_b=11, alu_op=00 (precomputes branch target). Next by opcode:
  - 100011 (lw) / 101011 (sw) -> MEM_ADDR
  - 000000 -> R_EXEC
  - 000100 (beq) -> BRANCH
  - 000010 (j) -> JUMP
  - 001000 (addi) -> I_EXEC
  - other -> FETCH, with illegal=1 for this cycle
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, alu_op=00. Next: lw -> MEM_RD, sw -> MEM_WR.
- MEM_RD (3): iord=1. Next: mem_ready ? MEM_WB : MEM_RD.
- MEM_WB (4): reg_dst=0, mem_to_reg=1, reg_we=1. Next: FETCH.
- MEM_WR (5): iord=1, mem_we=mem_ready. Next: mem_ready ? FETCH : MEM_WR.
- R_EXEC (6): alu_src_a=1, alu_src_b=00, alu_op=10. Next: R_WB.
- R_WB (7): reg_dst=1, mem_to_reg=0, reg_we=1. Next: FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_we=zero. Next: FETCH.
- JUMP (9): pc_src=10, pc_we=1. Next: FETCH.
- I_EXEC (10): alu_src_a=1, alu_src_b=10, alu_op=00. Next: I_WB.
- I_WB (11): reg_dst=0, mem_to_reg=0, reg_we=1. Next: FETCH.
- Codes 12–15 are unreachable. If entered, go to FETCH next cycle with all strobes 0.
- MEM_WAIT_EN=0: mem_ready is internally forced to 1, so FETCH, MEM_RD and MEM_WR each take one cycle.
- Cycle counts with mem_ready held high: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Opcode is sampled only in DECODE and MEM_ADDR. Changes to opcode in other states have no effect.
- rst asserted in any state, including mid-wait: FETCH next, immediately; no partial strobe survives.

Test Plan:
- Reset: assert rst mid-MEM_WR with mem_ready=1 -> mem_we=0 immediately, dbg_state=0. Release rst -> FETCH outputs: alu_src_b=01, iord=0.
- lw sequence: opcode=100011, mem_ready=1 -> states 0,1,2,3,4,0. reg_we=1 and mem_to_reg=1 only in cycle 5; ir_we=pc_we=1 in cycle 1.
- Memory stall: sw with mem_ready=0 for 3 cycles in MEM_WR -> state holds at 5 with mem_we=0, iord=1. Raise mem_ready -> mem_we=1 for exactly 1 cycle, then FETCH.
- beq: zero=1 -> pc_we=1, pc_src=01, alu_op=01 in BRANCH. Repeat with zero=0 -> pc_we=0. Both return to FETCH after 3 cycles.
- R-type, j, addi: verify per-state selects exactly as listed, e.g. R_WB has reg_dst=1; JUMP has pc_src=10 and pc_we=1; I_EXEC has alu_src_b=10.
- Illegal opcode 111111 -> illegal=1 in DECODE only, next state FETCH, no write strobes. With MEM_WAIT_EN=0 and mem_ready=0, lw still completes in 5 cycles.

Source files
------------

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control FSM: drives every datapath mux select and write strobe
// from the current state, the latched opcode, the ALU zero flag and mem_ready.
module mc_ctrl_fsm #(
  parameter int MEM_WAIT_EN = 1,
  parameter int STATE_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               pc_we,
  output logic               ir_we,
  output logic               mem_we,
  output logic               reg_we,
  output logic               iord,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic [1:0]         alu_op,
  output logic               illegal,
  output logic [STATE_W-1:0] dbg_state
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEM_ADDR = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEM_RD   = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEM_WB   = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEM_WR   = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_R_EXEC   = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_R_WB     = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_BRANCH   = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_JUMP     = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_I_EXEC   = STATE_W'(10);
  localparam logic [STATE_W-1:0] S_I_WB     = STATE_W'(11);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic               mem_rdy;

  assign mem_rdy   = (MEM_WAIT_EN != 0) ? mem_ready : 1'b1;
  assign dbg_state = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_I_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      // Opcode is re-sampled here; anything but lw/sw abandons the access.
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      state_d = S_MEM_RD;
        else if (opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FETCH;
      end
      S_MEM_RD:   if (mem_rdy) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_rdy) state_d = S_FETCH;
      S_R_EXEC:   state_d = S_R_WB;
      S_I_EXEC:   state_d = S_I_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_we      = 1'b0;
    ir_we      = 1'b0;
    mem_we     = 1'b0;
    reg_we     = 1'b0;
    iord       = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    pc_src     = 2'b00;
    alu_op     = 2'b00;
    illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_we     = mem_rdy;
        pc_we     = mem_rdy;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        illegal   = !(opcode inside {OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI});
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEM_RD: iord = 1'b1;
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_we     = 1'b1;
      end
      S_MEM_WR: begin
        iord   = 1'b1;
        mem_we = mem_rdy;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
      end
      S_R_WB: begin
        reg_dst = 1'b1;
        reg_we  = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b01;
        pc_src    = 2'b01;
        pc_we     = zero;
      end
      S_JUMP: begin
        pc_src = 2'b10;
        pc_we  = 1'b1;
      end
      S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_I_WB:  reg_we = 1'b1;
      default: ;
    endcase
    // Reset masks every strobe even though state_q already reads FETCH.
    if (rst) begin
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      mem_we  = 1'b0;
      reg_we  = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule
